tds_event_builder: RTL and testbench

- Parametrised trigger-matched event builder for sTGC TDS readout.
- Sits between NUM_CH per-channel FWFT data FIFOs and the Ethernet packetiser.
- On each accepted trigger it waits a programmable latency window, then drains each enabled channel in ascending order, up to MAX_WORDS words per channel.
- Output stream per event: one event header, the tagged data words, one trailer.

---
 rtl/tds_event_builder.sv | 252 +++++++++++++++++++++++++
 tb/tb_tds_event_builder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tds_event_builder.sv
// Trigger-matched event builder: after a programmable window, drains the enabled
// channel FIFOs in ascending order and frames the data with a header and trailer.
module tds_event_builder #(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 120,
    parameter int IDX_WIDTH  = 8,
    parameter int MAX_WORDS  = 64,
    parameter int WIN_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         trigger,
    input  logic [IDX_WIDTH-1:0]         trigger_index,
    input  logic [WIN_WIDTH-1:0]         window_len,
    input  logic [NUM_CH-1:0]            enable_mask,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_empty,
    output logic [NUM_CH-1:0]            ch_read,
    output logic [DATA_WIDTH-1:0]        out_tdata,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic                         out_tlast,
    output logic [1:0]                   out_type,
    output logic [4:0]                   out_chan,
    output logic                         busy,
    output logic [15:0]                  event_count,
    output logic [15:0]                  dropped_count
);
    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_WINDOW, S_HEADER, S_DRAIN, S_TRAILER
    } state_t;

    state_t                 state_reg, state_next;
    logic [WIN_WIDTH-1:0]   win_reg, win_next;
    logic [IDX_WIDTH-1:0]   idx_reg, idx_next;
    logic [NUM_CH-1:0]      mask_reg, mask_next;
    logic [NUM_CH-1:0]      trunc_reg, trunc_next;
    logic [15:0]            total_reg, total_next;
    logic [15:0]            wcnt_reg, wcnt_next;
    logic [15:0]            evt_reg, evt_next;
    logic [15:0]            drop_reg, drop_next;
    logic [4:0]             ptr_reg, ptr_next;

    logic                   tvalid_reg, tvalid_next;
    logic [DATA_WIDTH-1:0]  tdata_reg, tdata_next;
    logic [1:0]             type_reg, type_next;
    logic [4:0]             chan_reg, chan_next;
    logic                   tlast_reg, tlast_next;

    logic [DATA_WIDTH-1:0]  ch_word [NUM_CH];
    logic [DATA_WIDTH-1:0]  sel_word;
    logic                   sel_empty;
    logic [NUM_CH-1:0]      sel_onehot;
    logic                   next_found;
    logic [4:0]             next_ch;
    logic                   first_found;
    logic [4:0]             first_ch;
    logic [DATA_WIDTH-1:0]  hdr_word;
    logic [DATA_WIDTH-1:0]  trl_word;
    logic                   can_load;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_split
            assign ch_word[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Channel currently addressed by the drain pointer.
    always_comb begin
        sel_word   = '0;
        sel_empty  = 1'b1;
        sel_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ptr_reg == 5'(k)) begin
                sel_word      = ch_word[k];
                sel_empty     = ch_empty[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // Descending scans so the lowest qualifying channel wins.
    always_comb begin
        next_found  = 1'b0;
        next_ch     = '0;
        first_found = 1'b0;
        first_ch    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_reg[k] && (5'(k) > ptr_reg)) begin
                next_found = 1'b1;
                next_ch    = 5'(k);
            end
            if (mask_reg[k]) begin
                first_found = 1'b1;
                first_ch    = 5'(k);
            end
        end
    end

    always_comb begin
        hdr_word = '0;
        hdr_word[DATA_WIDTH-25 -: 16] = evt_reg;
        hdr_word[31:0]                = 32'(mask_reg);
        hdr_word[DATA_WIDTH-1 -: 8]   = 8'hA5;
        hdr_word[DATA_WIDTH-9 -: 16]  = 16'(idx_reg);
        trl_word = '0;
        trl_word[31:0]                = 32'(trunc_reg);
        trl_word[DATA_WIDTH-1 -: 8]   = 8'h5A;
        trl_word[DATA_WIDTH-9 -: 16]  = total_reg;
    end

    always_comb begin
        state_next  = state_reg;
        win_next    = win_reg;
        idx_next    = idx_reg;
        mask_next   = mask_reg;
        trunc_next  = trunc_reg;
        total_next  = total_reg;
        wcnt_next   = wcnt_reg;
        evt_next    = evt_reg;
        drop_next   = drop_reg;
        ptr_next    = ptr_reg;
        ch_read     = '0;
        can_load    = !tvalid_reg || out_tready;
        tvalid_next = tvalid_reg && !out_tready;
        tdata_next  = tdata_reg;
        type_next   = type_reg;
        chan_next   = chan_reg;
        tlast_next  = tlast_reg;

        if (trigger && (state_reg != S_IDLE) && (drop_reg != 16'hFFFF))
            drop_next = drop_reg + 16'd1;

        case (state_reg)
            S_IDLE: begin
                if (trigger) begin
                    idx_next   = trigger_index;
                    mask_next  = enable_mask;
                    win_next   = window_len;
                    trunc_next = '0;
                    total_next = '0;
                    ptr_next   = '0;
                    wcnt_next  = '0;
                    state_next = S_WINDOW;
                end
            end
            S_WINDOW: begin
                if (win_reg == '0)
                    state_next = S_HEADER;
                else
                    win_next = win_reg - 1'b1;
            end
            S_HEADER: begin
                if (can_load) begin
                    tvalid_next = 1'b1;
                    tdata_next  = hdr_word;
                    type_next   = 2'b01;
                    chan_next   = '0;
                    tlast_next  = 1'b0;
                    ptr_next    = first_ch;
                    wcnt_next   = '0;
                    state_next  = first_found ? S_DRAIN : S_TRAILER;
                end
            end
            S_DRAIN: begin
                // Empty is checked first: a channel that hit the limit exactly as it ran dry is not truncated.
                if (sel_empty || (wcnt_reg == MAX_W)) begin
                    if (!sel_empty)
                        trunc_next = trunc_reg | sel_onehot;
                    wcnt_next = '0;
                    if (next_found)
                        ptr_next = next_ch;
                    else
                        state_next = S_TRAILER;
                end else if (can_load) begin
                    ch_read     = sel_onehot;
                    tvalid_next = 1'b1;
                    tdata_next  = sel_word;
                    type_next   = 2'b00;
                    chan_next   = ptr_reg;
                    tlast_next  = 1'b0;
                    wcnt_next   = wcnt_reg + 16'd1;
                    total_next  = total_reg + 16'd1;
                end
            end
            S_TRAILER: begin
                // tlast in a valid stage marks the trailer as already loaded.
                if (tvalid_reg && tlast_reg) begin
                    if (out_tready) begin
                        evt_next   = evt_reg + 16'd1;
                        state_next = S_IDLE;
                    end
                end else if (can_load) begin
                    tvalid_next = 1'b1;
                    tdata_next  = trl_word;
                    type_next   = 2'b10;
                    chan_next   = '0;
                    tlast_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= S_IDLE;
            win_reg    <= '0;
            idx_reg    <= '0;
            mask_reg   <= '0;
            trunc_reg  <= '0;
            total_reg  <= '0;
            wcnt_reg   <= '0;
            evt_reg    <= '0;
            drop_reg   <= '0;
            ptr_reg    <= '0;
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
            type_reg   <= '0;
            chan_reg   <= '0;
            tlast_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            win_reg    <= win_next;
            idx_reg    <= idx_next;
            mask_reg   <= mask_next;
            trunc_reg  <= trunc_next;
            total_reg  <= total_next;
            wcnt_reg   <= wcnt_next;
            evt_reg    <= evt_next;
            drop_reg   <= drop_next;
            ptr_reg    <= ptr_next;
            tvalid_reg <= tvalid_next;
            tdata_reg  <= tdata_next;
            type_reg   <= type_next;
            chan_reg   <= chan_next;
            tlast_reg  <= tlast_next;
        end
    end

    assign out_tvalid    = tvalid_reg;
    assign out_tdata     = tdata_reg;
    assign out_type      = type_reg;
    assign out_chan      = chan_reg;
    assign out_tlast     = tlast_reg;
    assign busy          = (state_reg != S_IDLE);
    assign event_count   = evt_reg;
    assign dropped_count = drop_reg;

endmodule

// File: tb/tb_tds_event_builder.sv
// Scoreboard bench for tds_event_builder: FIFO models feed the DUT, expected words
// are queued by the stimulus and checked by an independent output monitor.
module tb_tds_event_builder;
    localparam int NCH = 8;
    localparam int DW  = 120;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    typ;
        logic [4:0]    chan;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              trigger;
    logic [7:0]        trigger_index;
    logic [9:0]        window_len;
    logic [NCH-1:0]    enable_mask;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_empty;
    logic [NCH-1:0]    ch_read;
    logic [DW-1:0]     out_tdata;
    logic              out_tvalid;
    logic              out_tready;
    logic              out_tlast;
    logic [1:0]        out_type;
    logic [4:0]        out_chan;
    logic              busy;
    logic [15:0]       event_count;
    logic [15:0]       dropped_count;

    logic [DW-1:0] fifo [NCH][$];
    exp_t          exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            rd_pulses = 0;
    logic          rand_ready = 1'b0;

    always #5 clk = ~clk;

    tds_event_builder #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .IDX_WIDTH(8), .MAX_WORDS(10), .WIN_WIDTH(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .trigger(trigger), .trigger_index(trigger_index),
        .window_len(window_len), .enable_mask(enable_mask), .ch_data(ch_data),
        .ch_empty(ch_empty), .ch_read(ch_read), .out_tdata(out_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .out_type(out_type), .out_chan(out_chan), .busy(busy),
        .event_count(event_count), .dropped_count(dropped_count)
    );

    function automatic logic [DW-1:0] mkw(input int ch, input int n);
        return {40'hDEAD_BEEF_00, 64'(ch * 1000 + n), 16'(n)};
    endfunction

    function automatic logic [DW-1:0] mk_hdr(input logic [7:0] idx, input logic [15:0] evt,
                                             input logic [7:0] mask);
        logic [DW-1:0] h;
        h = '0;
        h[119:112] = 8'hA5;
        h[111:96]  = {8'h00, idx};
        h[95:80]   = evt;
        h[7:0]     = mask;
        return h;
    endfunction

    function automatic logic [DW-1:0] mk_trl(input logic [15:0] cnt, input logic [7:0] trunc);
        logic [DW-1:0] t;
        t = '0;
        t[119:112] = 8'h5A;
        t[111:96]  = cnt;
        t[7:0]     = trunc;
        return t;
    endfunction

    task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] typ,
                            input int ch, input logic last);
        exp_t e;
        e.data = d; e.typ = typ; e.chan = 5'(ch); e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic expect_data(input int ch, input int first, input int count);
        for (int n = first; n < first + count; n++) push_exp(mkw(ch, n), 2'b00, ch, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < NCH; k++) begin
            ch_empty[k] = (fifo[k].size() == 0);
            ch_data[k*DW +: DW] = (fifo[k].size() != 0) ? fifo[k][0] : '0;
        end
    endtask

    task automatic fill(input int ch, input int first, input int count);
        for (int n = first; n < first + count; n++) fifo[ch].push_back(mkw(ch, n));
        refresh();
    endtask

    // One clock: observe the pop strobes mid-cycle, pop the FIFO models after the edge.
    task automatic step();
        logic [NCH-1:0] rd;
        @(negedge clk);
        rd = ch_read;
        if (rd != '0) begin
            n_cmp++;
            if (($countones(rd) != 1) || !busy) begin
                n_err++;
                $display("FAIL ch_read_onehot: got %b busy=%b, required one bit while busy", rd, busy);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (rd[k]) begin
                rd_pulses++;
                if (fifo[k].size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL read_empty: channel %0d popped while empty", k);
                end else begin
                    void'(fifo[k].pop_front());
                end
            end
        end
        refresh();
        if (rand_ready) out_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic fire(input logic [7:0] idx, input logic [7:0] mask, input logic [9:0] win);
        trigger = 1'b1; trigger_index = idx; enable_mask = mask; window_len = win;
        step();
        trigger = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int cyc = 0;
        while ((exp_q.size() != 0 || busy || out_tvalid) && cyc < budget) begin
            step();
            cyc++;
        end
        n_cmp++;
        if (cyc >= budget) begin
            n_err++;
            $display("FAIL %s_timeout: %0d words still expected after %0d cycles, required 0",
                     name, exp_q.size(), cyc);
        end
    endtask

    // Monitor: checks every accepted word against the scoreboard and hold stability.
    logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [1:0]    prev_type = '0;
    logic [4:0]    prev_chan = '0;
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && prev_rst && prev_valid && !prev_ready) begin
            n_cmp++;
            if (!out_tvalid || out_tdata !== prev_data || out_type !== prev_type ||
                out_chan !== prev_chan || out_tlast !== prev_last) begin
                n_err++;
                $display("FAIL hold: got v=%b d=%h, required v=1 d=%h", out_tvalid, out_tdata, prev_data);
            end
        end
        if (reset_n && out_tvalid && out_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got type=%b chan=%0d d=%h, required none",
                         out_type, out_chan, out_tdata);
            end else begin
                e = exp_q.pop_front();
                if (out_tdata !== e.data || out_type !== e.typ || out_chan !== e.chan ||
                    out_tlast !== e.last) begin
                    n_err++;
                    $display("FAIL word: got t=%b c=%0d l=%b d=%h, required t=%b c=%0d l=%b d=%h",
                             out_type, out_chan, out_tlast, out_tdata, e.typ, e.chan, e.last, e.data);
                end
            end
        end
        prev_valid = out_tvalid; prev_ready = out_tready; prev_rst = reset_n;
        prev_data = out_tdata; prev_type = out_type; prev_chan = out_chan; prev_last = out_tlast;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        reset_n = 1'b0; trigger = 1'b0; trigger_index = '0; window_len = '0;
        enable_mask = '0; out_tready = 1'b1; ch_empty = '1; ch_data = '0;
        refresh();
        repeat (3) step();
        check("reset_tvalid", 32'(out_tvalid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_event_count", 32'(event_count), 0);
        check("reset_dropped", 32'(dropped_count), 0);
        reset_n = 1'b1;
        step();

        // Event 0: ch0 two words, ch2 one word, window 3.
        fill(0, 0, 2); fill(2, 0, 1);
        push_exp(mk_hdr(8'h17, 16'd0, 8'h05), 2'b01, 0, 1'b0);
        expect_data(0, 0, 2); expect_data(2, 0, 1);
        push_exp(mk_trl(16'd3, 8'h00), 2'b10, 0, 1'b1);
        fire(8'h17, 8'h05, 10'd3);
        check("busy_after_trigger", 32'(busy), 1);
        lat = 0;
        while (!out_tvalid && lat < 50) begin step(); lat++; end
        check("header_latency_ge5", 32'(lat >= 5 && lat < 50), 1);
        wait_done("ev0", 200);
        check("ev0_event_count", 32'(event_count), 1);

        // Truncation at the 10-word limit; the leftovers form the next event.
        fill(1, 0, 12);
        push_exp(mk_hdr(8'h20, 16'd1, 8'h02), 2'b01, 0, 1'b0);
        expect_data(1, 0, 10);
        push_exp(mk_trl(16'd10, 8'h02), 2'b10, 0, 1'b1);
        fire(8'h20, 8'h02, 10'd0);
        wait_done("trunc", 300);
        check("trunc_left_in_fifo", 32'(fifo[1].size()), 2);
        push_exp(mk_hdr(8'h21, 16'd2, 8'h02), 2'b01, 0, 1'b0);
        expect_data(1, 10, 2);
        push_exp(mk_trl(16'd2, 8'h00), 2'b10, 0, 1'b1);
        fire(8'h21, 8'h02, 10'd1);
        wait_done("trunc2", 200);
        check("trunc2_event_count", 32'(event_count), 3);

        // Empty mask: header straight to trailer, no reads.
        fill(3, 0, 1);
        base = rd_pulses;
        push_exp(mk_hdr(8'h30, 16'd3, 8'h00), 2'b01, 0, 1'b0);
        push_exp(mk_trl(16'd0, 8'h00), 2'b10, 0, 1'b1);
        fire(8'h30, 8'h00, 10'd2);
        wait_done("mask0", 200);
        check("mask0_reads", 32'(rd_pulses - base), 0);

        // Dropped triggers: one during DRAIN, one on the trailer-accept cycle.
        fill(3, 1, 4);
        push_exp(mk_hdr(8'h40, 16'd4, 8'h08), 2'b01, 0, 1'b0);
        expect_data(3, 0, 5);
        push_exp(mk_trl(16'd5, 8'h00), 2'b10, 0, 1'b1);
        base = rd_pulses;
        fire(8'h40, 8'h08, 10'd2);
        lat = 0;
        while (rd_pulses == base && lat < 50) begin step(); lat++; end
        check("drop_reached_drain", 32'(rd_pulses != base), 1);
        fire(8'h41, 8'hFF, 10'd0);
        lat = 0;
        while (!(out_tvalid && out_tlast) && lat < 100) begin step(); lat++; end
        check("drop_trailer_seen", 32'(out_tvalid && out_tlast), 1);
        fire(8'h42, 8'hFF, 10'd0);
        wait_done("drop", 200);
        repeat (5) step();
        check("drop_count", 32'(dropped_count), 2);
        check("drop_no_second_event", 32'(busy), 0);
        check("drop_event_count", 32'(event_count), 5);

        // Full 8x10 event under random backpressure.
        for (int c = 0; c < NCH; c++) fill(c, 100, 10);
        push_exp(mk_hdr(8'h55, 16'd5, 8'hFF), 2'b01, 0, 1'b0);
        for (int c = 0; c < NCH; c++) expect_data(c, 100, 10);
        push_exp(mk_trl(16'd80, 8'h00), 2'b10, 0, 1'b1);
        base = rd_pulses;
        rand_ready = 1'b1;
        fire(8'h55, 8'hFF, 10'd4);
        wait_done("bp", 2000);
        rand_ready = 1'b0;
        out_tready = 1'b1;
        step();
        check("bp_read_pulses", 32'(rd_pulses - base), 80);
        check("bp_event_count", 32'(event_count), 6);

        // Reset while DRAIN is stalled behind an unaccepted header.
        fill(4, 0, 6);
        base = rd_pulses;
        out_tready = 1'b0;
        fire(8'h66, 8'h10, 10'd0);
        repeat (6) step();
        check("stall_no_reads", 32'(rd_pulses - base), 0);
        check("stall_busy", 32'(busy), 1);
        reset_n = 1'b0;
        step();
        check("rst_tvalid", 32'(out_tvalid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_event_count", 32'(event_count), 0);
        check("rst_dropped", 32'(dropped_count), 0);
        check("rst_fifo_untouched", 32'(fifo[4].size()), 6);
        reset_n = 1'b1;
        out_tready = 1'b1;
        step();
        push_exp(mk_hdr(8'h77, 16'd0, 8'h10), 2'b01, 0, 1'b0);
        expect_data(4, 0, 6);
        push_exp(mk_trl(16'd6, 8'h00), 2'b10, 0, 1'b1);
        fire(8'h77, 8'h10, 10'd1);
        wait_done("post_rst", 200);
        check("post_rst_event_count", 32'(event_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
